// File: rtl/keyboard_pkg.sv
// Shared keyboard definitions: key count, key-code width and event layout.
// Used by both the matrix-scanner side and the host-report side.
// No logic here; types and constants only.
package keyboard_pkg;

  localparam int NUM_KEYS  = 103;
  localparam int KEYCODE_W = 7;
  localparam int EVENT_W   = KEYCODE_W + 1;

  // One key event as it travels through the queue: {code, make}
  typedef struct packed {
    logic [KEYCODE_W-1:0] code;
    logic                 make;
  } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous show-ahead FIFO for key events, with full/empty/count.
// Latency: a push at edge t is visible at head_data after t; pop advances head next edge.
// Backpressure: push while full and pop while empty are ignored.
module key_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head is forced to zero when empty so the outputs are defined out of reset
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        count <= count + (AW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Debounces the scanner key bitmap one key per cycle and queues make/break events.
// Latency: push on the DEBOUNCE_SCANS-th differing visit, ev_valid one cycle later.
// Backpressure: when the queue is full the push is held off and retried next visit; nothing is lost.
module key_event_encoder #(
  parameter int NUM_KEYS       = keyboard_pkg::NUM_KEYS,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enabled,
  input  logic [NUM_KEYS:1]                 key_down,
  output logic                              ev_valid,
  input  logic                              ev_ready,
  output logic [keyboard_pkg::KEYCODE_W-1:0] ev_code,
  output logic                              ev_make,
  output logic                              busy
);

  import keyboard_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [KEYCODE_W-1:0] IDX_FIRST = KEYCODE_W'(1);
  localparam logic [KEYCODE_W-1:0] IDX_LAST  = KEYCODE_W'(NUM_KEYS);

  logic [KEYCODE_W-1:0] idx;
  logic [NUM_KEYS:1]    stable;
  logic [CNT_W-1:0]     cnt [1:NUM_KEYS];

  logic                 cur_level;
  logic                 cur_stable;
  logic [CNT_W-1:0]     cur_cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 at_threshold;
  logic                 push;
  logic                 any_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FCW-1:0]       fifo_count;
  key_event_t           ev_in;
  key_event_t           ev_head;

  // Debounce decision for the key under the cursor
  always_comb begin
    cur_level    = key_down[idx];
    cur_stable   = stable[idx];
    cur_cnt      = cnt[idx];
    at_threshold = (cur_cnt >= CNT_MAX);
    push         = 1'b0;
    cnt_next     = cur_cnt;
    if (cur_level == cur_stable) begin
      cnt_next = '0;
    end else if (!at_threshold) begin
      cnt_next = cur_cnt + CNT_W'(1);
    end else if (fifo_full) begin
      // Hold at the threshold so the very next visit retries the push
      cnt_next = CNT_MAX;
    end else begin
      push     = enabled;
      cnt_next = '0;
    end
    ev_in.code = idx;
    ev_in.make = cur_level;
  end

  // Cursor walk plus per-key counter and reported-level update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx    <= IDX_FIRST;
      stable <= '0;
      for (int k = 1; k <= NUM_KEYS; k++) begin
        cnt[k] <= '0;
      end
    end else if (enabled) begin
      idx      <= (idx == IDX_LAST) ? IDX_FIRST : idx + KEYCODE_W'(1);
      cnt[idx] <= cnt_next;
      if (push) begin
        stable[idx] <= cur_level;
      end
    end
  end

  // Any key mid-debounce keeps the block busy
  always_comb begin
    any_cnt = 1'b0;
    for (int k = 1; k <= NUM_KEYS; k++) begin
      any_cnt = any_cnt | (cnt[k] != '0);
    end
  end

  key_event_fifo #(
    .WIDTH (EVENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (ev_in),
    .pop       (ev_ready),
    .head_data (ev_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_code  = ev_head.code;
  assign ev_make  = ev_head.make;
  assign busy     = (fifo_count != '0) | any_cnt;

endmodule

// File: tb/tb_key_event_encoder.sv
// Bench for key_event_encoder: directed scenarios plus random key activity,
// checked every cycle against a queue-based behavioural model of the debouncer.
// Delivered events are also logged from the DUT handshake for scenario checks.
module tb_key_event_encoder;

  localparam int N     = 103;
  localparam int DS    = 4;
  localparam int DEPTH = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enabled = 1'b0;
  logic [N:1]   key_down = '0;
  logic         ev_valid;
  logic         ev_ready = 1'b0;
  logic [6:0]   ev_code;
  logic         ev_make;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: per-key reported level and visit count, cursor, event queue
  int m_stab [1:N];
  int m_cnt  [1:N];
  int m_cur;
  int m_q [$];
  // Events actually transferred by the DUT, encoded as code*2+make
  int log_q [$];
  int rk;

  key_event_encoder #(
    .NUM_KEYS       (N),
    .DEBOUNCE_SCANS (DS),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enabled  (enabled),
    .key_down (key_down),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_make  (ev_make),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 1; k <= N; k++) begin
      m_stab[k] = 0;
      m_cnt[k]  = 0;
    end
    m_cur = 1;
    m_q.delete();
  endtask

  function automatic bit model_busy();
    bit b;
    b = (m_q.size() != 0);
    for (int k = 1; k <= N; k++) if (m_cnt[k] != 0) b = 1'b1;
    return b;
  endfunction

  // One clock of the model: visit the cursor key, then apply pop and push
  task automatic model_step();
    bit full_now;
    bit do_push;
    int k;
    int lvl;
    int ev;
    full_now = (m_q.size() >= DEPTH);
    do_push  = 1'b0;
    ev       = 0;
    if (enabled) begin
      k   = m_cur;
      lvl = int'(key_down[k]);
      if (lvl == m_stab[k]) begin
        m_cnt[k] = 0;
      end else if (m_cnt[k] + 1 < DS) begin
        m_cnt[k] = m_cnt[k] + 1;
      end else if (!full_now) begin
        do_push   = 1'b1;
        ev        = k * 2 + lvl;
        m_stab[k] = lvl;
        m_cnt[k]  = 0;
      end else begin
        m_cnt[k] = DS - 1;
      end
      m_cur = (m_cur == N) ? 1 : m_cur + 1;
    end
    if (m_q.size() > 0 && ev_ready) void'(m_q.pop_front());
    if (do_push) m_q.push_back(ev);
  endtask

  function automatic int log_at(input int i);
    return (log_q.size() > i) ? log_q[i] : -1;
  endfunction

  // Advance the model on each edge and compare outputs just after it
  always @(posedge clock) begin
    if (!reset) model_step();
    #1;
    if (!reset) begin
      chk("valid", ev_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("code", ev_code, m_q[0] >> 1);
        chk("make", ev_make, m_q[0] & 1);
      end
      chk("busy", busy, model_busy());
    end
  end

  // Record handshakes that will complete at the coming rising edge
  always @(negedge clock) begin
    #2;
    if (!reset && ev_valid && ev_ready) log_q.push_back(int'(ev_code) * 2 + int'(ev_make));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_make", ev_make, 0);
    chk("rst_busy", busy, 0);
    cycles(2);
    reset    = 1'b0;
    enabled  = 1'b1;
    ev_ready = 1'b1;

    // Idle
    log_q.delete();
    cycles(1000); #3;
    chk("idle_events", log_q.size(), 0);
    chk("idle_busy", busy, 0);

    // Press then release key 17
    @(negedge clock);
    log_q.delete();
    key_down[17] = 1'b1;
    cycles(413); #3;
    chk("press_count", log_q.size(), 1);
    chk("press_event", log_at(0), 17 * 2 + 1);
    @(negedge clock);
    log_q.delete();
    key_down[17] = 1'b0;
    cycles(413); #3;
    chk("release_count", log_q.size(), 1);
    chk("release_event", log_at(0), 17 * 2);

    // Glitch of two sweeps on key 40
    @(negedge clock);
    log_q.delete();
    key_down[40] = 1'b1;
    cycles(206);
    key_down[40] = 1'b0;
    cycles(110); #3;
    chk("glitch_events", log_q.size(), 0);
    chk("glitch_busy", busy, 0);

    // Backpressure with ten simultaneous presses
    @(negedge clock);
    log_q.delete();
    ev_ready = 1'b0;
    key_down[10:1] = '1;
    cycles(420); #3;
    chk("bp_valid", ev_valid, 1);
    chk("bp_head_code", ev_code, 1);
    chk("bp_head_make", ev_make, 1);
    chk("bp_busy", busy, 1);
    chk("bp_no_transfer", log_q.size(), 0);
    @(negedge clock);
    ev_ready = 1'b1;
    cycles(200); #3;
    chk("bp_count", log_q.size(), 10);
    for (int i = 0; i < 10; i++) chk("bp_order", log_at(i), (i + 1) * 2 + 1);
    @(negedge clock);
    key_down = '0;
    cycles(450);
    log_q.delete();

    // Reset with three queued events, key 5 held through reset
    ev_ready    = 1'b0;
    key_down[5]  = 1'b1;
    key_down[20] = 1'b1;
    key_down[21] = 1'b1;
    cycles(420); #3;
    chk("mid_queued_valid", ev_valid, 1);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_code", ev_code, 0);
    chk("mid_rst_busy", busy, 0);
    cycles(2);
    reset       = 1'b0;
    key_down    = '0;
    key_down[5] = 1'b1;
    ev_ready    = 1'b1;
    log_q.delete();
    cycles(414); #3;
    chk("mid_count", log_q.size(), 1);
    chk("mid_event", log_at(0), 5 * 2 + 1);
    @(negedge clock);
    key_down[5] = 1'b0;
    cycles(420);

    // Enable gating
    log_q.delete();
    enabled     = 1'b0;
    key_down[5] = 1'b1;
    cycles(1000); #3;
    chk("gate_events", log_q.size(), 0);
    chk("gate_busy", busy, 0);
    @(negedge clock);
    enabled = 1'b1;
    cycles(414); #3;
    chk("gate_count", log_q.size(), 1);
    chk("gate_event", log_at(0), 5 * 2 + 1);
    @(negedge clock);
    key_down[5] = 1'b0;
    cycles(420);

    // Random activity on a cluster of keys with alternating ready phases
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 99) == 0) begin
        rk = $urandom_range(1, 12);
        key_down[rk] = ~key_down[rk];
      end
      if ($urandom_range(0, 1999) == 0) key_down[12:1] = ~key_down[12:1];
      if (((i / 500) % 2) == 0) ev_ready = ($urandom_range(0, 3) != 0);
      else                      ev_ready = ($urandom_range(0, 9) == 0);
      enabled = ($urandom_range(0, 15) != 0);
    end

    // Drain
    @(negedge clock);
    key_down = '0;
    enabled  = 1'b1;
    ev_ready = 1'b1;
    cycles(1000); #3;
    chk("end_valid", ev_valid, 0);
    chk("end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_encoder.md
# key_event_encoder

Converts the debounced-free `key_down[103:1]` bitmap produced by the matrix scanner into a lossless stream of make/break key events with a valid/ready handshake. Each key is debounced by requiring its new level on a number of consecutive sweeps. Events are queued in a small FIFO. The block sits between the matrix scanner and the host-protocol transmitter (USB/PS2 report builder), and is the consuming end of the scanner's key bitmap.

## Interface
Parameters:
- `NUM_KEYS`, 103: number of keys; valid key codes are 1..NUM_KEYS.
- `DEBOUNCE_SCANS`, 4: consecutive sweeps a key must show its new level before an event is issued (>=1).
- `FIFO_DEPTH`, 8: event queue depth (power of two).

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `enabled` in 1: sweep enable.
- `key_down` in [NUM_KEYS:1]: raw key levels from the scanner, 1 = pressed.
- `ev_valid` out 1: event available at FIFO head.
- `ev_ready` in 1: consumer accepts the head event.
- `ev_code` out 7: key index 1..NUM_KEYS of the head event.
- `ev_make` out 1: 1 = press (make), 0 = release (break).
- `busy` out 1: FIFO non-empty or any debounce counter non-zero.

## Operation
- Cursor `idx` walks 1..NUM_KEYS, one key per cycle while `enabled`=1.
  - It wraps from NUM_KEYS to 1.
  - One sweep is NUM_KEYS cycles.
  - When `enabled`=0, the cursor holds, counters hold, no pushes occur, and the FIFO still drains.
- Per-key state: `stable[k]` (last reported level) and `cnt[k]` (width clog2(DEBOUNCE_SCANS+1)).
- At each cursor visit to key k:
  - `key_down[k]==stable[k]`: clear `cnt[k]`.
  - Differs and `cnt[k]+1 < DEBOUNCE_SCANS`: increment `cnt[k]`.
  - Differs and `cnt[k]+1 >= DEBOUNCE_SCANS`:
    - FIFO not full: push {k, key_down[k]}, set `stable[k]` to the new level, clear `cnt[k]`.
    - FIFO full: no push; `stable[k]` unchanged; `cnt[k]` saturates at DEBOUNCE_SCANS-1. The push is retried on the next visit, so no events are lost.
- Full check uses the registered occupancy only. A pop in the same cycle does not free a slot for a push in that cycle.
- Event order equals push order. Within one sweep, events are issued in ascending key index.
- FIFO is show-ahead: `ev_code`/`ev_make` reflect the head whenever `ev_valid`=1.
- Transfer occurs when `ev_valid & ev_ready`. The head advances on the next edge.
- `ev_ready` while `ev_valid`=0 is ignored.
- `busy` is combinational from FIFO count and an OR of the counters (registered OR acceptable; it then lags by 1 cycle).

## Timing
- Reset values:
  - `stable`=0, `cnt`=0, `idx`=1, FIFO empty.
  - `ev_valid`=0, `ev_code`=0, `ev_make`=0, `busy`=0.
- Reset is asynchronous and discards queued events. A key still held after reset release is re-reported as make after debounce.
- Push-to-`ev_valid` latency: 1 cycle (pushed at edge t, visible after t).
- Detection latency: a level change stable before the cursor's next visit yields a push on the DEBOUNCE_SCANS-th visit. The worst case is DEBOUNCE_SCANS*NUM_KEYS cycles plus 1 to `ev_valid`.
- `ev_code`/`ev_make` are stable while `ev_valid`=1 and `ev_ready`=0.
- Throughput: 1 event per cycle on both push and pop.
- Glitch rejection: any return to the `stable` level before the threshold visit clears the count.

## Structure
- Shared package `keyboard_pkg`:
  - `NUM_KEYS`=103.
  - `KEYCODE_W`=7.
  - Event field layout {code[6:0], make}, used by both the scanner and host-side blocks.
- Sub-module `key_event_fifo`: synchronous FIFO with width KEYCODE_W+1, depth FIFO_DEPTH, show-ahead output, full/empty/count, async reset.
- Top level: cursor counter, `stable` and `cnt` arrays, and push logic.

## Test plan
1. **Idle after reset:** reset, then `key_down`=0, `ev_ready`=1 for 1000 cycles → `ev_valid` never asserted, `busy`=0.
2. **Press and release:** hold key 17 → exactly one event (code 17, make=1) within 413 cycles. Release → one event (code 17, make=0) within 413 cycles.
3. **Glitch rejection:** key 40 high for 206 cycles (2 sweeps) then low → no event, and `cnt` returns to 0.
4. **Backpressure, no loss:** `ev_ready`=0; press keys 1..10 together.
   - FIFO fills with codes 1..8 (make=1); `ev_code`=1 is held.
   - Raise `ev_ready` → codes 1..10 delivered in ascending order, each exactly once. Keys 9 and 10 arrive after their retry visits.
5. **Reset mid-operation:** with 3 events queued, assert reset → `ev_valid`=0 immediately. Release with key 5 still held → a single make event for code 5 after debounce.
6. **Enable gating:** `enabled`=0, press key 5 for 1000 cycles → no event. Set `enabled`=1 → make event for code 5 within 413 cycles.
